core_ctx_sched: RTL and testbench

Multi-context task sequencer that sits between a tile's CQ slice and one application core (HLS pipeline) able to hold `NUM_CTX` tasks in flight. It generalises the single-task core control loop (dequeue → inform CQ → start → finish/abort → drain) to independent per-context state machines with round-robin arbitration on the shared CQ and application channels. It also adds per-context child/undo/memory bookkeeping, and correct accounting when increments and decrements occur in the same cycle.

---
 rtl/core_ctx_sched.sv | 234 +++++++++++++++++++++++
 tb/tb_core_ctx_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctx_sched.sv
// core_ctx_sched: multi-context task sequencer between a CQ slice and one application core.
// Each context runs its own FSM; start/dispatch/abort/finish channels are shared round-robin.
module core_ctx_sched #(
  parameter int unsigned NUM_CTX   = 4,
  parameter int unsigned TASK_W    = 128,
  parameter int unsigned SLOT_W    = 8,
  parameter int unsigned CHILD_W   = 4,
  parameter int unsigned MEM_CNT_W = 3,
  localparam int unsigned CTX_W    = $clog2(NUM_CTX)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic               task_arvalid,
  input  logic               task_rvalid,
  input  logic [TASK_W-1:0]  task_rdata,
  input  logic [SLOT_W-1:0]  task_rslot,
  output logic               start_task_valid,
  input  logic               start_task_ready,
  output logic [SLOT_W-1:0]  start_task_slot,
  output logic               ap_start,
  input  logic               ap_ready,
  output logic [CTX_W-1:0]   ap_ctx,
  output logic [TASK_W-1:0]  ap_task,
  input  logic               ap_done,
  input  logic [CTX_W-1:0]   ap_done_ctx,
  output logic               ap_abort,
  output logic [CTX_W-1:0]   ap_abort_ctx,
  input  logic               ap_abort_ack,
  input  logic               enq_fire,
  input  logic [CTX_W-1:0]   enq_ctx,
  output logic               task_enq_untied,
  input  logic               undo_fire,
  input  logic [CTX_W-1:0]   undo_ctx,
  input  logic               ar_fire,
  input  logic [CTX_W-1:0]   ar_ctx,
  input  logic               rlast_fire,
  input  logic [CTX_W-1:0]   r_ctx,
  input  logic               aw_fire,
  input  logic [CTX_W-1:0]   aw_ctx,
  input  logic               b_fire,
  input  logic [CTX_W-1:0]   b_ctx,
  input  logic               abort_running_task,
  input  logic [SLOT_W-1:0]  abort_running_slot,
  input  logic               gvt_task_slot_valid,
  input  logic [SLOT_W-1:0]  gvt_task_slot,
  output logic               finish_task_valid,
  input  logic               finish_task_ready,
  output logic [SLOT_W-1:0]  finish_task_slot,
  output logic [CHILD_W-1:0] finish_task_num_children,
  output logic               finish_task_undo_log_write,
  output logic [NUM_CTX-1:0] ctx_busy
);

  typedef enum logic [2:0] {
    S_FREE, S_INFORM, S_DISPATCH, S_RUN, S_ABORT, S_FINISH, S_DRAIN
  } state_e;

  localparam int unsigned CH_START = 0;
  localparam int unsigned CH_DISP  = 1;
  localparam int unsigned CH_ABORT = 2;
  localparam int unsigned CH_FIN   = 3;
  localparam int unsigned NUM_CH   = 4;

  state_e               state_q     [NUM_CTX];
  logic [SLOT_W-1:0]    slot_q      [NUM_CTX];
  logic [TASK_W-1:0]    task_q      [NUM_CTX];
  logic [CHILD_W-1:0]   child_cnt_q [NUM_CTX];
  logic [CHILD_W-1:0]   child_cnt_d [NUM_CTX];
  logic [MEM_CNT_W-1:0] rd_cnt_q    [NUM_CTX];
  logic [MEM_CNT_W-1:0] rd_cnt_d    [NUM_CTX];
  logic [MEM_CNT_W-1:0] wr_cnt_q    [NUM_CTX];
  logic [MEM_CNT_W-1:0] wr_cnt_d    [NUM_CTX];
  logic [NUM_CTX-1:0]   abort_q, abort_d, undo_w_q, undo_w_d, free, load;
  logic                 untied_q, deq_fire;
  logic [CTX_W-1:0]     deq_idx;

  logic [NUM_CH-1:0][NUM_CTX-1:0] ch_req, ch_hit;
  logic [NUM_CH-1:0][CTX_W-1:0]   ch_ptr_q, ch_hold_q, ch_gnt;
  logic [NUM_CH-1:0]              ch_lock_q, ch_valid, ch_ready, ch_hs;

  function automatic logic [CTX_W-1:0] rr_pick(input logic [NUM_CTX-1:0] req,
                                               input logic [CTX_W-1:0]   ptr);
    logic [CTX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_CTX; k++) begin
      idx = ptr + CTX_W'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    ch_req  = '0;
    free    = '0;
    load    = '0;
    deq_idx = '0;
    for (int unsigned i = 0; i < NUM_CTX; i++) begin
      free[i]             = state_q[i] == S_FREE;
      ch_req[CH_START][i] = state_q[i] == S_INFORM;
      ch_req[CH_DISP][i]  = state_q[i] == S_DISPATCH && !abort_q[i];
      ch_req[CH_ABORT][i] = state_q[i] == S_ABORT;
      ch_req[CH_FIN][i]   = state_q[i] == S_FINISH;
    end
    for (int unsigned i = NUM_CTX; i > 0; i--)
      if (free[i-1]) deq_idx = CTX_W'(i-1);
    for (int unsigned i = 0; i < NUM_CTX; i++)
      load[i] = deq_fire && deq_idx == CTX_W'(i);
  end

  assign ch_ready = {finish_task_ready, ap_abort_ack, ap_ready, start_task_ready};

  // A grant is held only while its context still requests, so a dispatch squashed by abort releases the channel.
  always_comb begin
    ch_gnt   = '0;
    ch_valid = '0;
    ch_hs    = '0;
    ch_hit   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ch_gnt[c]   = (ch_lock_q[c] && ch_req[c][ch_hold_q[c]]) ? ch_hold_q[c]
                                                               : rr_pick(ch_req[c], ch_ptr_q[c]);
      ch_valid[c] = |ch_req[c];
      ch_hs[c]    = ch_valid[c] & ch_ready[c];
      ch_hit[c]   = ch_hs[c] ? (NUM_CTX'(1) << ch_gnt[c]) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_ptr_q  <= '0;
      ch_hold_q <= '0;
      ch_lock_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_hs[c]) begin
          ch_ptr_q[c]  <= ch_gnt[c] + CTX_W'(1);
          ch_lock_q[c] <= 1'b0;
        end else begin
          ch_lock_q[c] <= ch_valid[c];
          ch_hold_q[c] <= ch_gnt[c];
        end
      end
    end
  end

  // Counters use plain modulo add/sub so a same-cycle increment and decrement nets to zero.
  always_comb begin
    abort_d  = abort_q;
    undo_w_d = undo_w_q;
    for (int unsigned i = 0; i < NUM_CTX; i++) begin
      child_cnt_d[i] = child_cnt_q[i];
      if (enq_fire && !untied_q && enq_ctx == CTX_W'(i))
        child_cnt_d[i] = child_cnt_q[i] + CHILD_W'(1);
      if (undo_fire && undo_ctx == CTX_W'(i))
        undo_w_d[i] = 1'b1;
      rd_cnt_d[i] = rd_cnt_q[i] + MEM_CNT_W'(ar_fire && ar_ctx == CTX_W'(i))
                                - MEM_CNT_W'(rlast_fire && r_ctx == CTX_W'(i));
      wr_cnt_d[i] = wr_cnt_q[i] + MEM_CNT_W'(aw_fire && aw_ctx == CTX_W'(i))
                                - MEM_CNT_W'(b_fire && b_ctx == CTX_W'(i));
      if (abort_running_task && abort_running_slot == slot_q[i] &&
          state_q[i] inside {S_INFORM, S_DISPATCH, S_RUN})
        abort_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      untied_q <= 1'b0;
      abort_q  <= '0;
      undo_w_q <= '0;
      for (int unsigned i = 0; i < NUM_CTX; i++) begin
        state_q[i]     <= S_FREE;
        slot_q[i]      <= '0;
        task_q[i]      <= '0;
        child_cnt_q[i] <= '0;
        rd_cnt_q[i]    <= '0;
        wr_cnt_q[i]    <= '0;
      end
    end else begin
      untied_q <= gvt_task_slot_valid && gvt_task_slot == slot_q[enq_ctx];
      for (int unsigned i = 0; i < NUM_CTX; i++) begin
        if (load[i]) begin
          state_q[i]     <= S_INFORM;
          slot_q[i]      <= task_rslot;
          task_q[i]      <= task_rdata;
          abort_q[i]     <= 1'b0;
          undo_w_q[i]    <= 1'b0;
          child_cnt_q[i] <= '0;
          rd_cnt_q[i]    <= '0;
          wr_cnt_q[i]    <= '0;
        end else begin
          abort_q[i]     <= abort_d[i];
          undo_w_q[i]    <= undo_w_d[i];
          child_cnt_q[i] <= child_cnt_d[i];
          rd_cnt_q[i]    <= rd_cnt_d[i];
          wr_cnt_q[i]    <= wr_cnt_d[i];
          case (state_q[i])
            S_INFORM:   if (ch_hit[CH_START][i]) state_q[i] <= abort_q[i] ? S_FINISH : S_DISPATCH;
            S_DISPATCH: if (abort_q[i]) state_q[i] <= S_FINISH;
                        else if (ch_hit[CH_DISP][i]) state_q[i] <= S_RUN;
            S_RUN:      if (ap_done && ap_done_ctx == CTX_W'(i)) state_q[i] <= S_FINISH;
                        else if (abort_q[i]) state_q[i] <= S_ABORT;
            S_ABORT:    if (ch_hit[CH_ABORT][i]) state_q[i] <= S_FINISH;
            S_FINISH:   if (ch_hit[CH_FIN][i])
                          state_q[i] <= (rd_cnt_q[i] != '0 || wr_cnt_q[i] != '0) ? S_DRAIN : S_FREE;
            S_DRAIN:    if (rd_cnt_q[i] == '0 && wr_cnt_q[i] == '0) state_q[i] <= S_FREE;
            default:    ;
          endcase
        end
      end
    end
  end

  assign task_arvalid               = enable & |free;
  assign deq_fire                   = task_arvalid & task_rvalid;
  assign start_task_valid           = ch_valid[CH_START];
  assign start_task_slot            = ch_valid[CH_START] ? slot_q[ch_gnt[CH_START]] : '0;
  assign ap_start                   = ch_valid[CH_DISP];
  assign ap_ctx                     = ch_valid[CH_DISP] ? ch_gnt[CH_DISP] : '0;
  assign ap_task                    = ch_valid[CH_DISP] ? task_q[ch_gnt[CH_DISP]] : '0;
  assign ap_abort                   = ch_valid[CH_ABORT];
  assign ap_abort_ctx               = ch_valid[CH_ABORT] ? ch_gnt[CH_ABORT] : '0;
  assign finish_task_valid          = ch_valid[CH_FIN];
  assign finish_task_slot           = ch_valid[CH_FIN] ? slot_q[ch_gnt[CH_FIN]] : '0;
  assign finish_task_num_children   = ch_valid[CH_FIN] ? child_cnt_q[ch_gnt[CH_FIN]] : '0;
  assign finish_task_undo_log_write = ch_valid[CH_FIN] & undo_w_q[ch_gnt[CH_FIN]];
  assign task_enq_untied            = untied_q;
  assign ctx_busy                   = ~free;

endmodule

// File: tb/tb_core_ctx_sched.sv
// Directed bench for core_ctx_sched; dispatch and finish transactions are scoreboarded.
module tb_core_ctx_sched;
  localparam int unsigned NUM_CTX = 4, TASK_W = 128, SLOT_W = 8, CHILD_W = 4, MEM_CNT_W = 3;
  localparam int unsigned CTX_W = 2;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic task_arvalid, task_rvalid = 1'b0;
  logic [TASK_W-1:0] task_rdata = '0;
  logic [SLOT_W-1:0] task_rslot = '0;
  logic start_task_valid, start_task_ready = 1'b1;
  logic [SLOT_W-1:0] start_task_slot;
  logic ap_start, ap_ready = 1'b1;
  logic [CTX_W-1:0] ap_ctx;
  logic [TASK_W-1:0] ap_task;
  logic ap_done = 1'b0;
  logic [CTX_W-1:0] ap_done_ctx = '0;
  logic ap_abort, ap_abort_ack = 1'b0;
  logic [CTX_W-1:0] ap_abort_ctx;
  logic enq_fire = 1'b0, undo_fire = 1'b0, task_enq_untied;
  logic [CTX_W-1:0] enq_ctx = '0, undo_ctx = '0;
  logic ar_fire = 1'b0, rlast_fire = 1'b0, aw_fire = 1'b0, b_fire = 1'b0;
  logic [CTX_W-1:0] ar_ctx = '0, r_ctx = '0, aw_ctx = '0, b_ctx = '0;
  logic abort_running_task = 1'b0;
  logic [SLOT_W-1:0] abort_running_slot = '0;
  logic gvt_task_slot_valid = 1'b0;
  logic [SLOT_W-1:0] gvt_task_slot = '0;
  logic finish_task_valid, finish_task_ready = 1'b1;
  logic [SLOT_W-1:0] finish_task_slot;
  logic [CHILD_W-1:0] finish_task_num_children;
  logic finish_task_undo_log_write;
  logic [NUM_CTX-1:0] ctx_busy;

  core_ctx_sched #(.NUM_CTX(NUM_CTX), .TASK_W(TASK_W), .SLOT_W(SLOT_W),
                   .CHILD_W(CHILD_W), .MEM_CNT_W(MEM_CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .task_arvalid(task_arvalid), .task_rvalid(task_rvalid),
    .task_rdata(task_rdata), .task_rslot(task_rslot),
    .start_task_valid(start_task_valid), .start_task_ready(start_task_ready),
    .start_task_slot(start_task_slot),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_ctx(ap_ctx), .ap_task(ap_task),
    .ap_done(ap_done), .ap_done_ctx(ap_done_ctx),
    .ap_abort(ap_abort), .ap_abort_ctx(ap_abort_ctx), .ap_abort_ack(ap_abort_ack),
    .enq_fire(enq_fire), .enq_ctx(enq_ctx), .task_enq_untied(task_enq_untied),
    .undo_fire(undo_fire), .undo_ctx(undo_ctx),
    .ar_fire(ar_fire), .ar_ctx(ar_ctx), .rlast_fire(rlast_fire), .r_ctx(r_ctx),
    .aw_fire(aw_fire), .aw_ctx(aw_ctx), .b_fire(b_fire), .b_ctx(b_ctx),
    .abort_running_task(abort_running_task), .abort_running_slot(abort_running_slot),
    .gvt_task_slot_valid(gvt_task_slot_valid), .gvt_task_slot(gvt_task_slot),
    .finish_task_valid(finish_task_valid), .finish_task_ready(finish_task_ready),
    .finish_task_slot(finish_task_slot),
    .finish_task_num_children(finish_task_num_children),
    .finish_task_undo_log_write(finish_task_undo_log_write),
    .ctx_busy(ctx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [CTX_W+TASK_W-1:0]    exp_disp[$];
  logic [SLOT_W+CHILD_W:0]    exp_fin[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TASK_W-1:0] mk_task(input logic [SLOT_W-1:0] s);
    logic [TASK_W-1:0] pat;
    pat = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    return {16{s}} ^ pat;
  endfunction

  always @(negedge clk) begin
    if (!rst && ap_start && ap_ready) begin
      chk("disp_expected", exp_disp.size() != 0, 1);
      if (exp_disp.size() != 0) chk("disp_payload", {ap_ctx, ap_task}, exp_disp.pop_front());
    end
    if (!rst && finish_task_valid && finish_task_ready) begin
      chk("fin_expected", exp_fin.size() != 0, 1);
      if (exp_fin.size() != 0)
        chk("fin_payload", {finish_task_slot, finish_task_num_children, finish_task_undo_log_write},
            exp_fin.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic deq(input logic [SLOT_W-1:0] s, input logic [CTX_W-1:0] c, input bit disp);
    logic [TASK_W-1:0] t;
    t = mk_task(s);
    task_rvalid = 1'b1;
    task_rdata  = t;
    task_rslot  = s;
    chk("arvalid", task_arvalid, 1);
    if (disp) exp_disp.push_back({c, t});
    tick();
    task_rvalid = 1'b0;
  endtask

  task automatic done(input logic [CTX_W-1:0] c, input logic [SLOT_W-1:0] s,
                      input logic [CHILD_W-1:0] ch, input logic u);
    ap_done     = 1'b1;
    ap_done_ctx = c;
    exp_fin.push_back({s, ch, u});
    tick();
    ap_done = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", ctx_busy, 0);
    chk("rst_arvalid", task_arvalid, 0);
    chk("rst_start", start_task_valid, 0);
    chk("rst_apstart", ap_start, 0);
    chk("rst_abort", ap_abort, 0);
    chk("rst_finish", finish_task_valid, 0);
    chk("rst_untied", task_enq_untied, 0);
    rst = 1'b0;
    enable = 1'b1;
    tick();

    // single task, minimum latency
    deq(8'd5, 2'd0, 1'b1);
    chk("t1_start_valid", start_task_valid, 1);
    chk("t1_start_slot", start_task_slot, 5);
    chk("t1_busy", ctx_busy, 4'b0001);
    tick();
    chk("t1_apstart", ap_start, 1);
    chk("t1_apctx", ap_ctx, 0);
    chk("t1_start_low", start_task_valid, 0);
    tick();
    chk("t1_run_apstart_low", ap_start, 0);
    repeat (4) tick();
    done(2'd0, 8'd5, 4'd0, 1'b0);
    chk("t1_fin_valid", finish_task_valid, 1);
    chk("t1_fin_slot", finish_task_slot, 5);
    tick();
    chk("t1_free", ctx_busy, 0);
    chk("t1_fin_low", finish_task_valid, 0);

    // four tasks, finish stalled then drained in order
    finish_task_ready = 1'b0;
    deq(8'd1, 2'd0, 1'b1);
    deq(8'd2, 2'd1, 1'b1);
    deq(8'd3, 2'd2, 1'b1);
    deq(8'd4, 2'd3, 1'b1);
    chk("t2_all_busy", ctx_busy, 4'hf);
    chk("t2_no_free_arvalid", task_arvalid, 0);
    repeat (3) tick();
    done(2'd0, 8'd1, 4'd0, 1'b0);
    done(2'd1, 8'd2, 4'd0, 1'b0);
    done(2'd2, 8'd3, 4'd0, 1'b0);
    done(2'd3, 8'd4, 4'd0, 1'b0);
    repeat (6) begin
      chk("t2_stall_valid", finish_task_valid, 1);
      chk("t2_stall_slot", finish_task_slot, 1);
      tick();
    end
    finish_task_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("t2_fin_order", finish_task_slot, k);
      tick();
    end
    chk("t2_all_free", ctx_busy, 0);

    // abort while running
    deq(8'd3, 2'd0, 1'b1);
    repeat (2) tick();
    abort_running_task = 1'b1;
    abort_running_slot = 8'd3;
    tick();
    abort_running_task = 1'b0;
    chk("t3_abort_not_yet", ap_abort, 0);
    tick();
    repeat (3) begin
      chk("t3_ap_abort", ap_abort, 1);
      chk("t3_ap_abort_ctx", ap_abort_ctx, 0);
      tick();
    end
    ap_abort_ack = 1'b1;
    exp_fin.push_back({8'd3, 4'd0, 1'b0});
    tick();
    ap_abort_ack = 1'b0;
    chk("t3_abort_cleared", ap_abort, 0);
    chk("t3_fin_valid", finish_task_valid, 1);
    tick();
    chk("t3_free", ctx_busy, 0);

    // abort while waiting for dispatch: no dispatch happens
    ap_ready = 1'b0;
    deq(8'd7, 2'd0, 1'b0);
    tick();
    chk("t3d_apstart", ap_start, 1);
    abort_running_task = 1'b1;
    abort_running_slot = 8'd7;
    exp_fin.push_back({8'd7, 4'd0, 1'b0});
    tick();
    abort_running_task = 1'b0;
    chk("t3d_apstart_dropped", ap_start, 0);
    tick();
    chk("t3d_fin_slot", finish_task_slot, 7);
    ap_ready = 1'b1;
    tick();
    chk("t3d_free", ctx_busy, 0);

    // memory drain on ctx1
    deq(8'd10, 2'd0, 1'b1);
    deq(8'd11, 2'd1, 1'b1);
    repeat (3) tick();
    ar_fire = 1'b1; ar_ctx = 2'd1;
    aw_fire = 1'b1; aw_ctx = 2'd1;
    tick();
    aw_fire = 1'b0;
    tick();
    r_ctx = 2'd1;
    rlast_fire = 1'b1;
    tick();
    ar_fire = 1'b0;
    rlast_fire = 1'b0;
    done(2'd0, 8'd10, 4'd0, 1'b0);
    done(2'd1, 8'd11, 4'd0, 1'b0);
    chk("t4_fin_slot", finish_task_slot, 11);
    repeat (3) begin
      tick();
      chk("t4_drain_hold", ctx_busy, 4'b0010);
    end
    rlast_fire = 1'b1;
    tick();
    rlast_fire = 1'b0;
    chk("t4_drain_rd1", ctx_busy, 4'b0010);
    rlast_fire = 1'b1;
    b_fire = 1'b1; b_ctx = 2'd1;
    tick();
    rlast_fire = 1'b0;
    b_fire = 1'b0;
    chk("t4_drain_last", ctx_busy, 4'b0010);
    tick();
    chk("t4_free", ctx_busy, 0);

    // children and undo on ctx2
    deq(8'd20, 2'd0, 1'b1);
    deq(8'd21, 2'd1, 1'b1);
    deq(8'd22, 2'd2, 1'b1);
    repeat (3) tick();
    enq_ctx = 2'd2;
    enq_fire = 1'b1;
    repeat (3) tick();
    enq_fire = 1'b0;
    gvt_task_slot_valid = 1'b1;
    gvt_task_slot = 8'd21;
    tick();
    chk("t5_untied_mismatch", task_enq_untied, 0);
    gvt_task_slot = 8'd22;
    tick();
    chk("t5_untied_match", task_enq_untied, 1);
    enq_fire = 1'b1;
    tick();
    enq_fire = 1'b0;
    gvt_task_slot_valid = 1'b0;
    undo_fire = 1'b1; undo_ctx = 2'd2;
    tick();
    undo_fire = 1'b0;
    done(2'd2, 8'd22, 4'd3, 1'b1);
    chk("t5_children", finish_task_num_children, 3);
    chk("t5_undo", finish_task_undo_log_write, 1);
    tick();
    chk("t5_busy", ctx_busy, 4'b0011);

    // asynchronous reset with three contexts busy
    deq(8'd23, 2'd2, 1'b1);
    repeat (3) tick();
    chk("t6_busy3", ctx_busy, 4'b0111);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", ctx_busy, 0);
    chk("t6_rst_start", start_task_valid, 0);
    chk("t6_rst_apstart", ap_start, 0);
    chk("t6_rst_abort", ap_abort, 0);
    chk("t6_rst_finish", finish_task_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    deq(8'd9, 2'd0, 1'b1);
    chk("t6_start_slot", start_task_slot, 9);
    repeat (2) tick();
    done(2'd0, 8'd9, 4'd0, 1'b0);
    chk("t6_fin_valid", finish_task_valid, 1);
    tick();
    chk("t6_free", ctx_busy, 0);

    chk("disp_queue_empty", exp_disp.size(), 0);
    chk("fin_queue_empty", exp_fin.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
